ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/hack_mem_pkg.sv | 6 +
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/ram_arb_starve_ctr.sv | 20 ++
 rtl/ram_arbiter.sv | 59 +++++
 tb/tb_ram_arbiter.sv | 136 +++++++++++++
 5 files changed

// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared RAM widths and the read-owner state encoding for ram_arbiter.
package hack_mem_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} owner_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU port, DMA port and RAM16K side of the arbiter; slave = arbiter, master = environment.
interface ram_arbiter_if;
  import hack_mem_pkg::*;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in, ram_out;
  logic              ram_load;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_out,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_addr, ram_in, ram_load
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_out,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_addr, ram_in, ram_load
  );
endinterface

// File: rtl/ram_arb_starve_ctr.sv
// ram_arb_starve_ctr: counts consecutive CPU-won conflicts, saturating at FAIR_LIMIT.
module ram_arb_starve_ctr #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic conflict,
  input  logic dma_win,
  output logic at_limit
);
  logic [3:0] cnt_q, cnt_d;
  assign at_limit = cnt_q == 4'(FAIR_LIMIT);
  always_comb begin
    cnt_d = (dma_win || !conflict) ? 4'd0 : at_limit ? cnt_q : cnt_q + 4'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM16K between CPU and DMA ports; CPU priority,
// with DMA anti-starvation after FAIR_LIMIT lost conflicts when RAM_ARB_FAIR_EN is defined.
module ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  ram_arbiter_if.slave bus
);
  owner_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic              at_limit;
  if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_limit
    $error("ram_arbiter: FAIR_LIMIT must be in 1..15");
  end
`ifdef RAM_ARB_FAIR_EN
  logic conflict;
  assign conflict = bus.cpu_req & bus.dma_req;
  ram_arb_starve_ctr #(.FAIR_LIMIT(FAIR_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .conflict (conflict),
    .dma_win  (bus.dma_gnt),
    .at_limit (at_limit)
  );
`else
  assign at_limit = 1'b0;
`endif
  // Grants are gated by reset so nothing reaches the RAM while it is asserted.
  assign bus.dma_gnt = reset & bus.dma_req & (~bus.cpu_req | at_limit);
  assign bus.cpu_gnt = reset & bus.cpu_req & ~bus.dma_gnt;
  assign bus.ram_load = (bus.cpu_gnt & bus.cpu_we) | (bus.dma_gnt & bus.dma_we);
  assign bus.ram_addr = ram_addr_d;
  assign bus.ram_in = ram_in_d;
  always_comb begin
    ram_addr_d = bus.cpu_gnt ? bus.cpu_addr : bus.dma_gnt ? bus.dma_addr : ram_addr_q;
    ram_in_d = bus.cpu_gnt ? bus.cpu_wdata : bus.dma_gnt ? bus.dma_wdata : ram_in_q;
    state_d = (bus.cpu_gnt && !bus.cpu_we) ? CPU_RD :
              (bus.dma_gnt && !bus.dma_we) ? DMA_RD : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ram_addr_q <= '0;
      ram_in_q <= '0;
    end else begin
      state_q <= state_d;
      ram_addr_q <= ram_addr_d;
      ram_in_q <= ram_in_d;
    end
  end
  assign bus.cpu_rvalid = state_q == CPU_RD;
  assign bus.dma_rvalid = state_q == DMA_RD;
  assign bus.cpu_rdata = bus.cpu_rvalid ? bus.ram_out : '0;
  assign bus.dma_rdata = bus.dma_rvalid ? bus.ram_out : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a 1-cycle-latency RAM model.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;
  logic [15:0] mem [0:16383];
  ram_arbiter_if bus ();
  ram_arbiter #(.FAIR_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_load) mem[bus.ram_addr] <= bus.ram_in;
    bus.ram_out <= mem[bus.ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic drive(input logic cr, input logic cw, input logic [13:0] ca,
                       input logic dr, input logic dw, input logic [13:0] da, input logic [15:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = 16'h0;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
  endtask
  function automatic logic dma_turn(input int i);
`ifdef RAM_ARB_FAIR_EN
    return (i % 5) == 4;
`else
    return (i < 0);
`endif
  endfunction
  initial begin
    mem[14'h0010] = 16'hBEEF;
    mem[14'h0000] = 16'h0000;
    bus.ram_out = 16'h0;
    drive(1, 0, 14'h0010, 1, 1, 14'h0020, 16'h5555);
    #2;
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_ram_load", bus.ram_load, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_in", bus.ram_in, 0);
    chk("rst_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
    chk("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    // CPU read alone
    @(negedge clk);
    drive(1, 0, 14'h0010, 0, 0, 0, 0);
    #1;
    chk("cpu_rd_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
    chk("cpu_rd_addr", bus.ram_addr, 14'h0010);
    chk("cpu_rd_load", bus.ram_load, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("cpu_rvalid", bus.cpu_rvalid, 1);
    chk("cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    chk("dma_idle", {bus.dma_rvalid, bus.dma_rdata}, 0);
    chk("addr_hold", bus.ram_addr, 14'h0010);
    // DMA write then read
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 14'h3FFF, 16'h1234);
    #1;
    chk("dma_wr_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b01);
    chk("dma_wr_load", bus.ram_load, 1);
    chk("dma_wr_addr", bus.ram_addr, 14'h3FFF);
    chk("dma_wr_data", bus.ram_in, 16'h1234);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 14'h3FFF, 0);
    #1;
    chk("wr_no_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("dma_rvalid", bus.dma_rvalid, 1);
    chk("dma_rdata", bus.dma_rdata, 16'h1234);
    chk("idle_load", bus.ram_load, 0);
    // alternating reads, no bubble
    @(negedge clk);
    drive(1, 0, 14'h0010, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 14'h3FFF, 0);
    #1;
    chk("alt_cpu_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b10);
    chk("alt_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alt_dma_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b01);
    chk("alt_dma_rdata", bus.dma_rdata, 16'h1234);
    chk("alt_cpu_rdata0", bus.cpu_rdata, 0);
    // continuous conflict
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, 0, 14'h0010, 1, 0, 14'h3FFF, 0);
      #1;
      chk($sformatf("conf_gnt%0d", i), {bus.cpu_gnt, bus.dma_gnt}, dma_turn(i) ? 2'b01 : 2'b10);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    // build the counter to 3, then reset during the in-flight read of the last win
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 0, 14'h0010, 1, 0, 14'h3FFF, 0);
      #1;
      chk($sformatf("pre_gnt%0d", i), {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rst_drop_rvalid", bus.cpu_rvalid, 0);
    chk("rst_drop_rdata", bus.cpu_rdata, 0);
    chk("rst_addr_clr", bus.ram_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("no_replay%0d", i), {bus.cpu_rvalid, bus.dma_rvalid}, 0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 1, 14'h0001, 1, 1, 14'h0002, 16'h0);
      #1;
      chk($sformatf("post_rst_gnt%0d", i), {bus.cpu_gnt, bus.dma_gnt}, dma_turn(i) ? 2'b01 : 2'b10);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("final_no_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
